frame_sequencer: RTL and testbench

Central frame scheduler on the clk24 domain. It sequences one camera frame through three stages: capture into the capture buffer, the `core` resolution-reduction pass, and LeNet inference. It replaces the free-running `lenet_control` handshake with an explicit per-frame state machine, driven by the run and pause switches. It latches the inferred digit for the VGA overlay and counts completed frames.

---
 rtl/frame_sequencer.sv | 181 ++++++++++++++++++
 tb/tb_frame_sequencer.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/frame_sequencer.sv
// ============================================================================
// Module   : frame_sequencer
// Brief    : Per-frame scheduler on the clk24 domain. Steps one camera frame
//            through capture, the core resolution-reduction pass and LeNet
//            inference, latches the inferred digit and counts frames.
//            Optional LeNet watchdog: define FRAME_SEQ_WATCHDOG_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module frame_sequencer #(
  parameter int FRAME_CNT_W   = 16,
  parameter int READY_TIMEOUT = 2_000_000
) (
  input  logic                   clk24,
  input  logic                   rst,
  input  logic                   sw_run,
  input  logic                   sw_pause,
  input  logic                   capture_end,
  input  logic                   core_end,
  input  logic                   lenet_data_ready,
  input  logic                   lenet_ready,
  input  logic [3:0]             lenet_digit,
  output logic                   capture_en,
  output logic                   core_start,
  output logic                   lenet_go,
  output logic [3:0]             digit_out,
  output logic                   digit_valid,
  output logic                   busy,
  output logic [FRAME_CNT_W-1:0] frame_count,
  output logic                   error
);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_CAPTURE   = 3'd1,
    S_PROCESS   = 3'd2,
    S_WAIT_DATA = 3'd3,
    S_GO        = 3'd4,
    S_RUN_ACK   = 3'd5,
    S_RUN_DONE  = 3'd6,
    S_HOLD      = 3'd7
  } state_t;

  state_t r_state;
  state_t w_next;

  logic r_cap_s1;
  logic r_cap_s2;
  logic r_cap_s3;
  logic r_core_d;
  logic w_cap_rise;
  logic w_core_rise;
  logic w_timeout;
  logic w_done;
  logic w_start_session;

  // capture_end comes from the pixel-clock domain: two flops to synchronise,
  // a third to find its rising edge; core_end only needs edge detection
  always_ff @(posedge clk24 or posedge rst) begin
    if (rst) begin
      r_cap_s1 <= 1'b0;
      r_cap_s2 <= 1'b0;
      r_cap_s3 <= 1'b0;
      r_core_d <= 1'b0;
    end else begin
      r_cap_s1 <= capture_end;
      r_cap_s2 <= r_cap_s1;
      r_cap_s3 <= r_cap_s2;
      r_core_d <= core_end;
    end
  end

  assign w_cap_rise  = r_cap_s2 & ~r_cap_s3;
  assign w_core_rise = core_end & ~r_core_d;

`ifdef FRAME_SEQ_WATCHDOG_EN
  localparam int c_WD_W = $clog2(READY_TIMEOUT + 1);

  logic [c_WD_W-1:0] r_wd_cnt;
  logic              r_error;
  logic              w_wait_state;

  assign w_wait_state = (r_state == S_WAIT_DATA) || (r_state == S_RUN_ACK) ||
                        (r_state == S_RUN_DONE);
  assign w_timeout    = w_wait_state && (r_wd_cnt == c_WD_W'(READY_TIMEOUT - 1));

  // Watchdog counts cycles spent in the current LeNet wait state; restarts
  // on every state change
  always_ff @(posedge clk24 or posedge rst) begin
    if (rst) begin
      r_wd_cnt <= '0;
    end else if (!w_wait_state || (w_next != r_state)) begin
      r_wd_cnt <= '0;
    end else begin
      r_wd_cnt <= r_wd_cnt + c_WD_W'(1);
    end
  end

  // Sticky error flag, cleared only by reset
  always_ff @(posedge clk24 or posedge rst) begin
    if (rst) begin
      r_error <= 1'b0;
    end else if (w_timeout) begin
      r_error <= 1'b1;
    end
  end

  assign error = r_error;
`else
  assign w_timeout = 1'b0;
  // Constant 0 for any legal timeout; keeps the parameter referenced
  assign error     = (READY_TIMEOUT < 0);
`endif

  // State register
  always_ff @(posedge clk24 or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state logic; a watchdog expiry overrides every other transition
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:      if (sw_run && !sw_pause) w_next = S_CAPTURE;
      S_CAPTURE:   if (w_cap_rise) w_next = S_PROCESS;
      S_PROCESS:   if (w_core_rise) w_next = S_WAIT_DATA;
      S_WAIT_DATA: if (lenet_data_ready && lenet_ready) w_next = S_GO;
      S_GO:        w_next = S_RUN_ACK;
      S_RUN_ACK:   if (!lenet_ready) w_next = S_RUN_DONE;
      S_RUN_DONE: begin
        if (lenet_ready) begin
          if (sw_pause)    w_next = S_HOLD;
          else if (sw_run) w_next = S_CAPTURE;
          else             w_next = S_IDLE;
        end
      end
      S_HOLD: begin
        if (!sw_pause) w_next = sw_run ? S_CAPTURE : S_IDLE;
      end
      default:     w_next = S_IDLE;
    endcase
    if (w_timeout) w_next = S_IDLE;
  end

  assign w_done          = (r_state == S_RUN_DONE) && lenet_ready && !w_timeout;
  assign w_start_session = (r_state == S_IDLE) && (w_next == S_CAPTURE);

  // Registered outputs, decoded from the upcoming state so they line up
  // with the state they belong to
  always_ff @(posedge clk24 or posedge rst) begin
    if (rst) begin
      capture_en  <= 1'b0;
      core_start  <= 1'b0;
      lenet_go    <= 1'b0;
      busy        <= 1'b0;
      digit_out   <= 4'd0;
      digit_valid <= 1'b0;
      frame_count <= '0;
    end else begin
      capture_en <= (w_next == S_CAPTURE);
      core_start <= (r_state == S_CAPTURE) && (w_next == S_PROCESS);
      lenet_go   <= (w_next == S_GO);
      busy       <= (w_next != S_IDLE);
      if (w_done) begin
        digit_out   <= lenet_digit;
        digit_valid <= 1'b1;
        frame_count <= frame_count + FRAME_CNT_W'(1);
      end else if (w_start_session) begin
        digit_valid <= 1'b0;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_frame_sequencer.sv
// ============================================================================
// Module   : tb_frame_sequencer
// Brief    : Self-checking bench for frame_sequencer. Expected frame results
//            are queued by the stimulus and compared by an output monitor.
//            Build with FRAME_SEQ_WATCHDOG_EN to exercise the watchdog.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_frame_sequencer;

  localparam int c_FCW     = 3;
  localparam int c_TIMEOUT = 100;

  logic             clk24 = 1'b0;
  logic             rst = 1'b1;
  logic             sw_run = 1'b0;
  logic             sw_pause = 1'b0;
  logic             capture_end = 1'b0;
  logic             core_end = 1'b0;
  logic             lenet_data_ready = 1'b0;
  logic             lenet_ready = 1'b1;
  logic [3:0]       lenet_digit = 4'd0;
  logic             capture_en;
  logic             core_start;
  logic             lenet_go;
  logic [3:0]       digit_out;
  logic             digit_valid;
  logic             busy;
  logic [c_FCW-1:0] frame_count;
  logic             error;

  frame_sequencer #(
    .FRAME_CNT_W   (c_FCW),
    .READY_TIMEOUT (c_TIMEOUT)
  ) dut (
    .clk24            (clk24),
    .rst              (rst),
    .sw_run           (sw_run),
    .sw_pause         (sw_pause),
    .capture_end      (capture_end),
    .core_end         (core_end),
    .lenet_data_ready (lenet_data_ready),
    .lenet_ready      (lenet_ready),
    .lenet_digit      (lenet_digit),
    .capture_en       (capture_en),
    .core_start       (core_start),
    .lenet_go         (lenet_go),
    .digit_out        (digit_out),
    .digit_valid      (digit_valid),
    .busy             (busy),
    .frame_count      (frame_count),
    .error            (error)
  );

  always #5 clk24 = ~clk24;

  typedef logic [4+1+c_FCW-1:0] exp_t;   // {digit_out, digit_valid, frame_count}

  int               n_checks = 0;
  int               n_fail   = 0;
  exp_t             exp_q[$];
  logic [c_FCW-1:0] exp_fc   = '0;
  int               go_count = 0;
  int               cs_count = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk24);
  endtask

  function automatic logic sig(input int which);
    return (which == 0) ? capture_en : lenet_go;
  endfunction

  // Bounded wait for capture_en (0) or lenet_go (1)
  task automatic wait_sig(input int which, input string name, input int budget);
    int i = 0;
    while (!sig(which) && i < budget) begin
      tick(1);
      i++;
    end
    check(name, sig(which), 1);
  endtask

  task automatic check_reset(input string pfx);
    check({pfx, "_capture_en"},  capture_en,  0);
    check({pfx, "_core_start"},  core_start,  0);
    check({pfx, "_lenet_go"},    lenet_go,    0);
    check({pfx, "_digit_out"},   digit_out,   0);
    check({pfx, "_digit_valid"}, digit_valid, 0);
    check({pfx, "_busy"},        busy,        0);
    check({pfx, "_frame_count"}, frame_count, 0);
    check({pfx, "_error"},       error,       0);
  endtask

  // One complete frame starting from (or heading into) CAPTURE
  task automatic do_frame(input logic [3:0] d, input bit pause_mid, input bit drop_run);
    wait_sig(0, "capture_en_wait", 4);
    capture_end = 1'b1;
    tick(2);
    check("core_start_early", core_start, 0);
    tick(1);
    check("core_start_latency", core_start, 1);
    tick(1);
    check("core_start_width", core_start, 0);
    capture_end = 1'b0;
    if (pause_mid) sw_pause = 1'b1;
    if (drop_run)  sw_run   = 1'b0;
    core_end = 1'b1;
    tick(1);
    core_end = 1'b0;
    tick(3);
    check("go_needs_data_ready", lenet_go, 0);
    lenet_data_ready = 1'b1;
    wait_sig(1, "lenet_go_wait", 4);
    lenet_data_ready = 1'b0;
    lenet_ready      = 1'b0;
    tick(2);
    lenet_digit = d;
    lenet_ready = 1'b1;
    exp_fc = exp_fc + 1'b1;
    exp_q.push_back({d, 1'b1, exp_fc});
    tick(2);
  endtask

  // Runs a frame up to the point where lenet_go has just been seen
  task automatic to_go();
    wait_sig(0, "capture_en_wait", 4);
    capture_end = 1'b1;
    tick(3);
    capture_end = 1'b0;
    core_end = 1'b1;
    tick(1);
    core_end = 1'b0;
    lenet_data_ready = 1'b1;
    wait_sig(1, "lenet_go_wait", 6);
    lenet_data_ready = 1'b0;
  endtask

  // Output monitor: compares each frame completion against the queue and
  // watches lenet_go / core_start pulses
  logic [c_FCW-1:0] prev_fc = '0;
  logic             prev_go = 1'b0;
  logic             prev_cs = 1'b0;
  exp_t             mon_e;

  always @(negedge clk24) begin
    if (rst) begin
      prev_fc = frame_count;
      prev_go = 1'b0;
      prev_cs = 1'b0;
    end else begin
      if (frame_count !== prev_fc) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_frame: got count %0d, expected no completion", frame_count);
        end else begin
          mon_e = exp_q.pop_front();
          check("frame_result", {digit_out, digit_valid, frame_count}, mon_e);
        end
        prev_fc = frame_count;
      end
      if (lenet_go) check("lenet_go_single_cycle", prev_go, 0);
      if (lenet_go && !prev_go)   go_count++;
      if (core_start && !prev_cs) cs_count++;
      prev_go = lenet_go;
      prev_cs = core_start;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    int go0;
    int cs0;

    // Reset state
    tick(2);
    check_reset("reset");
    rst = 1'b0;
    tick(2);
    check("idle_busy", busy, 0);
    check("idle_capture_en", capture_en, 0);

    // First frame, digit 7
    sw_run = 1'b1;
    wait_sig(0, "capture_en_after_run", 2);
    check("busy_in_capture", busy, 1);
    do_frame(4'd7, 1'b0, 1'b0);
    check("f1_digit", digit_out, 7);
    check("f1_valid", digit_valid, 1);
    check("f1_count", frame_count, 1);

    // Fresh reset, then three back-to-back frames
    rst = 1'b1;
    tick(2);
    rst = 1'b0;
    exp_fc = '0;
    go0 = go_count;
    do_frame(4'd1, 1'b0, 1'b0);
    do_frame(4'd2, 1'b0, 1'b0);
    do_frame(4'd3, 1'b0, 1'b0);
    check("run3_count", frame_count, 3);
    check("run3_digit", digit_out, 3);
    check("run3_go_pulses", go_count - go0, 3);

    // core_end during CAPTURE is ignored
    wait_sig(0, "capture_en_wait", 4);
    cs0 = cs_count;
    core_end = 1'b1;
    tick(1);
    core_end = 1'b0;
    tick(3);
    check("stray_core_end_capture", capture_en, 1);
    check("stray_core_end_no_start", cs_count - cs0, 0);
    do_frame(4'd4, 1'b0, 1'b0);

    // Pause raised during PROCESS: frame finishes, then HOLD
    do_frame(4'd5, 1'b1, 1'b0);
    check("hold_capture_en", capture_en, 0);
    check("hold_busy", busy, 1);
    tick(5);
    check("hold_stays", capture_en, 0);
    sw_pause = 1'b0;
    wait_sig(0, "resume_capture", 2);

    // Run dropped mid-frame: frame completes, then IDLE
    do_frame(4'd6, 1'b0, 1'b1);
    check("drop_run_idle_busy", busy, 0);
    check("drop_run_capture_en", capture_en, 0);
    check("drop_run_valid_kept", digit_valid, 1);
    tick(3);
    sw_run = 1'b1;
    tick(1);
    check("restart_capture_en", capture_en, 1);
    check("restart_valid_cleared", digit_valid, 0);
    check("restart_digit_kept", digit_out, 6);
    do_frame(4'd9, 1'b0, 1'b0);
    do_frame(4'd8, 1'b0, 1'b0);
    check("count_wrap", frame_count, 0);
    do_frame(4'd2, 1'b0, 1'b0);
    check("count_after_wrap", frame_count, 1);

    // LeNet never returns ready
    to_go();
    sw_run      = 1'b0;
    lenet_ready = 1'b0;
    tick(1000);
`ifdef FRAME_SEQ_WATCHDOG_EN
    check("wd_error", error, 1);
    check("wd_idle", busy, 0);
    lenet_ready = 1'b1;
    tick(2);
    check("wd_error_sticky", error, 1);
`else
    check("nowd_error", error, 0);
    check("nowd_still_busy", busy, 1);
    check("nowd_no_capture", capture_en, 0);
    lenet_digit = 4'd4;
    lenet_ready = 1'b1;
    exp_fc = exp_fc + 1'b1;
    exp_q.push_back({4'd4, 1'b1, exp_fc});
    tick(2);
    check("nowd_late_done_idle", busy, 0);
`endif

    // Reset asserted while in RUN_ACK
    sw_run = 1'b1;
    to_go();
    tick(2);
    check("runack_busy", busy, 1);
    rst = 1'b1;
    #1;
    check_reset("async_reset");
    tick(2);
    rst = 1'b0;
    exp_fc = '0;
    sw_run = 1'b0;
    tick(3);

    check("queue_drained", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
